// File: rtl/chop_phase_sequencer.sv
// Start-up, settle and non-overlapping phi1/phi2 chopper sequencer for the chopped bandgap.
// Optional half-period dither is built when CHOP_DITHER_EN is defined.
module chop_phase_sequencer #(
  parameter int HP_W        = 8,
  parameter int DT_W        = 3,
  parameter int STARTUP_CYC = 16,
  parameter int SETTLE_CYC  = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [HP_W-1:0] half_period,
  input  logic [DT_W-1:0] dead_time,
  output logic            phi1,
  output logic            phi2,
  output logic            startup_kick,
  output logic            sample_stb,
  output logic            ready
);

  // Longest load is a dithered half period (2^HP_W - 1 + 3) or one of the fixed phases.
  localparam int HALF_MAX = (1 << HP_W) + 3;
  localparam int FIX_MAX  = (SETTLE_CYC > STARTUP_CYC) ? SETTLE_CYC : STARTUP_CYC;
  localparam int CNT_MAX  = (HALF_MAX > FIX_MAX) ? HALF_MAX : FIX_MAX;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE, STARTUP, SETTLE, RUN_P1, DEAD_12, RUN_P2, DEAD_21
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [CNT_W-1:0] hq, hq_next;
  logic [CNT_W-1:0] dq, dq_next;
  logic [CNT_W-1:0] h_in, d_in;
  logic [1:0]       dither;
  logic             last;
  logic             enter_p1;

  assign h_in = (half_period == '0) ? CNT_ONE : CNT_W'(half_period);
  assign d_in = (dead_time == '0) ? CNT_ONE : CNT_W'(dead_time);
  assign last = (cnt == CNT_ONE);

`ifdef CHOP_DITHER_EN
  logic [7:0] lfsr, lfsr_next, lfsr_adv;

  // x^8+x^6+x^5+x^4+1, shifted left; the freshly advanced value dithers the new period.
  assign lfsr_adv = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign dither   = lfsr_adv[1:0];
  assign lfsr_next = enter_p1 ? lfsr_adv : lfsr;

  always_ff @(posedge clk) begin
    if (rst) lfsr <= 8'hA5;
    else     lfsr <= lfsr_next;
  end
`else
  assign dither = 2'd0;
`endif

  // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    state_next = state;
    cnt_next   = cnt - CNT_ONE;
    hq_next    = hq;
    dq_next    = dq;
    enter_p1   = 1'b0;

    if (!en) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_next = STARTUP;
          cnt_next   = CNT_W'(STARTUP_CYC);
        end
        STARTUP: if (last) begin
          state_next = SETTLE;
          cnt_next   = CNT_W'(SETTLE_CYC);
        end
        SETTLE:  if (last) enter_p1 = 1'b1;
        RUN_P1: if (last) begin
          state_next = DEAD_12;
          cnt_next   = dq;
        end
        DEAD_12: if (last) begin
          state_next = RUN_P2;
          cnt_next   = hq;
        end
        RUN_P2: if (last) begin
          state_next = DEAD_21;
          cnt_next   = dq;
        end
        DEAD_21: if (last) enter_p1 = 1'b1;
        default: state_next = IDLE;
      endcase
    end

    // Period boundary: config is sampled here so mid-period input changes wait for the next period.
    if (enter_p1) begin
      state_next = RUN_P1;
      hq_next    = h_in + CNT_W'(dither);
      dq_next    = d_in;
      cnt_next   = h_in + CNT_W'(dither);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      hq           <= CNT_ONE;
      dq           <= CNT_ONE;
      phi1         <= 1'b0;
      phi2         <= 1'b0;
      startup_kick <= 1'b0;
      sample_stb   <= 1'b0;
      ready        <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      hq           <= hq_next;
      dq           <= dq_next;
      // Outputs are decoded from the next state and registered, so they track state glitch-free.
      phi1         <= (state_next == SETTLE) || (state_next == RUN_P1);
      phi2         <= (state_next == RUN_P2);
      startup_kick <= (state_next == STARTUP);
      sample_stb   <= (state_next == DEAD_21) && (cnt_next == CNT_ONE);
      ready        <= (state_next == RUN_P1) || (state_next == DEAD_12) ||
                      (state_next == RUN_P2) || (state_next == DEAD_21);
    end
  end

endmodule

// File: tb/tb_chop_phase_sequencer.sv
// Scoreboard bench for chop_phase_sequencer: expected per-period phase lengths are queued by the
// stimulus and checked by a monitor on every sample_stb. Define CHOP_DITHER_EN to match a dither build.
module tb_chop_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] half_period;
  logic [2:0] dead_time;
  logic       phi1, phi2, startup_kick, sample_stb, ready;

  always #5 clk = ~clk;

  chop_phase_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .half_period  (half_period),
    .dead_time    (dead_time),
    .phi1         (phi1),
    .phi2         (phi2),
    .startup_kick (startup_kick),
    .sample_stb   (sample_stb),
    .ready        (ready)
  );

  typedef struct {
    int unsigned p1;
    int unsigned d12;
    int unsigned p2;
    int unsigned d21;
  } per_t;

  per_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] m_lfsr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference dither: seed 8'hA5, x^8+x^6+x^5+x^4+1, one step per period start.
  function automatic void model_reset();
    m_lfsr = 8'hA5;
  endfunction

  function automatic int unsigned model_adv();
`ifdef CHOP_DITHER_EN
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    return int'(m_lfsr[1:0]);
`else
    return 0;
`endif
  endfunction

  task automatic push_per(input int unsigned h, input int unsigned d, input int cnt);
    int unsigned hh, dd, add;
    hh = (h == 0) ? 1 : h;
    dd = (d == 0) ? 1 : d;
    for (int i = 0; i < cnt; i++) begin
      add = model_adv();
      exp_q.push_back('{p1: hh + add, d12: dd, p2: hh + add, d21: dd});
    end
  endtask

  // Monitor: measure phase lengths within each ready period, compare at sample_stb.
  int unsigned m_p1 = 0, m_d12 = 0, m_p2 = 0, m_d21 = 0;
  bit          m_seen2 = 1'b0;

  always @(negedge clk) begin
    per_t e;
    if (!ready) begin
      m_p1 = 0; m_d12 = 0; m_p2 = 0; m_d21 = 0; m_seen2 = 1'b0;
    end else begin
      check("overlap", {31'd0, phi1 & phi2}, 0);
      if (phi1)         m_p1++;
      else if (phi2)    begin m_p2++; m_seen2 = 1'b1; end
      else if (!m_seen2) m_d12++;
      else              m_d21++;
      if (sample_stb) begin
        if (exp_q.size() == 0) begin
          check("unexpected_stb", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("p1_len",    m_p1,  e.p1);
          check("d12_len",   m_d12, e.d12);
          check("p2_len",    m_p2,  e.p2);
          check("d21_len",   m_d21, e.d21);
          check("p1_eq_p2",  m_p1,  m_p2);
        end
        m_p1 = 0; m_d12 = 0; m_p2 = 0; m_d21 = 0; m_seen2 = 1'b0;
      end
    end
  end

  function automatic bit sig(input int sel);
    return (sel == 0) ? startup_kick : (phi1 && !ready);
  endfunction

  // Wait (bounded) for a run of sig(sel), then return its length in cycles.
  task automatic run_len(input int sel, output int unsigned n);
    int w = 0;
    while (!sig(sel) && w < 300) begin @(negedge clk); w++; end
    n = 0;
    while (sig(sel) && n < 300) begin n++; @(negedge clk); end
  endtask

  task automatic wait_stb(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!sample_stb && n < 400);
    check({name, "_stb"}, {31'd0, sample_stb}, 1);
  endtask

  task automatic wait_phi2(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!phi2 && n < 400);
    check({name, "_phi2"}, {31'd0, phi2}, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    rst = 1'b1; en = 1'b0; half_period = 8'd4; dead_time = 3'd2;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_out", {27'd0, phi1, phi2, startup_kick, sample_stb, ready}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_out", {27'd0, phi1, phi2, startup_kick, sample_stb, ready}, 0);

    // Start-up: kick 16, settle 64, then 4/2/4/2 periods.
    en = 1'b1;
    run_len(0, n);
    check("kick_len", n, 16);
    push_per(4, 2, 3);
    run_len(1, n);
    check("settle_len", n, 64);
    check("ready_rise", {30'd0, phi1, ready}, 3);
    repeat (3) wait_stb("start");

    // Minimum values take effect at the next period start.
    half_period = 8'd0; dead_time = 3'd0;
    push_per(0, 0, 3);
    repeat (3) wait_stb("min");

    // Mid-period change during RUN_P2 of the second period.
    half_period = 8'd4; dead_time = 3'd2;
    push_per(4, 2, 2);
    push_per(8, 2, 2);
    wait_stb("chg_a");
    wait_phi2("chg");
    half_period = 8'd8;
    repeat (3) wait_stb("chg_b");

    // Enable drop on the second RUN_P2 cycle of an unscored period.
    void'(model_adv());
    wait_phi2("drop");
    @(negedge clk);
    check("drop_p2_2nd", {31'd0, phi2}, 1);
    en = 1'b0;
    @(negedge clk);
    check("drop_out", {27'd0, phi1, phi2, startup_kick, sample_stb, ready}, 0);
    repeat (3) @(negedge clk);
    en = 1'b1;
    run_len(0, n);
    check("rekick_len", n, 16);

    // Reset pulse mid-SETTLE with en held high.
    repeat (10) @(negedge clk);
    check("in_settle", {30'd0, phi1, ready}, 2);
    rst = 1'b1;
    @(negedge clk);
    check("rst_out", {27'd0, phi1, phi2, startup_kick, sample_stb, ready}, 0);
    rst = 1'b0;
    model_reset();
    half_period = 8'd4;
    run_len(0, n);
    check("restart_kick_len", n, 16);
    push_per(4, 2, 2);
    run_len(1, n);
    check("restart_settle_len", n, 64);
    check("restart_ready_rise", {30'd0, phi1, ready}, 3);
    repeat (2) wait_stb("restart");

`ifdef CHOP_DITHER_EN
    push_per(4, 2, 256);
    repeat (256) wait_stb("dither");
`endif

    @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
